kbd_event_ctrl: RTL and testbench
=================================

Name: kbd_event_ctrl

Overview:
- Sequences the PS/2 receive FIFO (ps2_keyboard) by driving its nextdata_n pop strobe, instead of leaving it tied low.
- Assembles raw scan bytes into whole key events: make/break, E0-extended, E1 Pause sequence.
- Tracks modifier and Caps Lock state.
- Presents one event at a time to a consumer (ascii/display logic) over a valid/ready handshake, with backpressure into the PS/2 FIFO.

Parameters:
- PAUSE_LEN, 7, number of bytes following E1 that are absorbed into one Pause event.

Ports:
- clk  in  1  system clock
- clr  in  1  reset; synchronous, active-high
- ps2_byte  in  8  FIFO head byte from ps2_keyboard.data
- ps2_ready  in  1  FIFO non-empty, from ps2_keyboard.ready
- ps2_overflow  in  1  FIFO overflow, from ps2_keyboard.overflow
- nextdata_n  out  1  registered pop strobe to ps2_keyboard, active-low
- evt_valid  out  1  event register full
- evt_ready  in  1  consumer accepts event
- evt_code  out  8  final scan code (8'hE1 for Pause)
- evt_break  out  1  1 = key release
- evt_ext  out  1  code was E0/E1-prefixed
- evt_mods  out  4  {caps_lock, alt, ctrl, shift}, snapshot after this event's update
- ovf_sticky  out  1  ps2_overflow was seen since reset
- kbd_err  out  1  sticky; keyboard sent 8'h00 or 8'hFF

Behaviour:
- Reset (clr=1 at posedge):
  - nextdata_n=1; evt_valid=0; evt_code=0; evt_break=0; evt_ext=0; evt_mods=0; ovf_sticky=0; kbd_err=0.
  - All pending flags, held bits, caps_lock and skip counter clear; FSM goes to IDLE.
  - Bytes already in the PS/2 FIFO are kept and processed after reset.
  - A partially assembled sequence is lost.
- FSM states: IDLE, POP, DECODE.
  - IDLE: if ps2_ready && !evt_valid, latch ps2_byte into byte_r, set nextdata_n<=0, go to POP. Otherwise stay; nextdata_n stays 1.
  - POP: nextdata_n<=1, go to DECODE. The low pulse is exactly one cycle per byte.
  - DECODE: classify byte_r, update state, go to IDLE.
  - Throughput is 3 cycles per byte. A new event's evt_valid rises on the edge that leaves DECODE.
- Backpressure:
  - No byte is popped while evt_valid=1, including prefix bytes.
  - evt_valid clears on the posedge where evt_valid && evt_ready.
  - A fetch starts no earlier than the following cycle, so there is no same-cycle accept-and-fetch.
  - Event outputs are stable while evt_valid=1.
- DECODE classification (priority order):
  - skip_cnt>0: discard the byte and decrement skip_cnt. On reaching 0, emit an event with code E1, ext=1, break=0.
  - 8'hE1: skip_cnt<=PAUSE_LEN; no event.
  - 8'hE0: ext_pend<=1; no event.
  - 8'hF0: brk_pend<=1; no event. E0 and F0 may arrive in either order.
  - 8'hAA, FA, EE, FE: discard; pending flags unchanged.
  - 8'h00, FF: kbd_err<=1; clear ext_pend and brk_pend; no event.
  - Code 12 or 59 with ext_pend=1 (fake shift): discard; clear both pending flags; no event.
  - Any other byte: update modifiers, then emit an event with break=brk_pend and ext=ext_pend. Clear both pending flags.
- Modifier update:
  - shift = lshift(12) | rshift(59).
  - ctrl = lctrl(14) | rctrl(E0 14).
  - alt = lalt(11) | ralt(E0 11).
  - Each held bit is set on make and cleared on break.
  - Caps (58): on make while caps_held=0, toggle caps_lock and set caps_held. On break, clear caps_held. Typematic repeats do not toggle caps_lock.
- Overflow: ps2_overflow=1 in any cycle sets ovf_sticky. Operation continues; only clr clears it.

Decomposition:
- Shared package kbd_pkg holds:
  - Scan-code constants: E0, E1, F0, AA, FA, EE, FE, LSHIFT, RSHIFT, CTRL, ALT, CAPS.
  - FSM state enum.
  - Mods-bit index constants.
- One sub-module, kbd_mod_tracker:
  - Inputs: code, ext, break, strobe.
  - Outputs: the 4-bit mods.
  - Owns the held bits and caps_lock.

Test Plan:
- FIFO holds 1C, evt_ready=1 → one nextdata_n low pulse; evt_valid high 3 cycles after ready sampled; code=1C, break=0, ext=0, mods=0.
- Bytes 12,1C,F0,1C,F0,12 → events: 12 make (mods=0001), 1C make (mods=0001), 1C break (mods=0001), 12 break (mods=0000); exactly 6 pops.
- E0,F0,75 then F0,E0,75 → two events, both code=75, break=1, ext=1. E0,12 → no event, mods unchanged.
- 58,58,58,F0,58 → caps_lock=1 after first make; remains 1 through repeats and break. Second 58 make cycle → caps_lock=0.
- E1,14,77,E1,F0,14,F0,77 → exactly one event: code=E1, ext=1, break=0; 8 pops. Byte 00 → kbd_err=1. ps2_overflow pulse → ovf_sticky=1.
- evt_ready=0 with 1C,32 queued → one pop only; nextdata_n stays 1 until the accept. Assert clr in POP → nextdata_n=1 and all outputs zero next cycle; 32 is then delivered normally.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared definitions for the keyboard event controller.
//   - PS/2 set-2 scan-code constants used by the decoder and modifier tracker
//   - controller FSM state type
//   - bit positions inside the 4-bit modifier vector {caps, alt, ctrl, shift}
package kbd_pkg;

   // Prefix and protocol bytes
   localparam logic [7:0] ScE0 = 8'hE0;  // extended-code prefix
   localparam logic [7:0] ScE1 = 8'hE1;  // Pause sequence prefix
   localparam logic [7:0] ScF0 = 8'hF0;  // break (release) prefix
   localparam logic [7:0] ScAA = 8'hAA;  // self-test passed
   localparam logic [7:0] ScFA = 8'hFA;  // acknowledge
   localparam logic [7:0] ScEE = 8'hEE;  // echo
   localparam logic [7:0] ScFE = 8'hFE;  // resend request
   localparam logic [7:0] Sc00 = 8'h00;  // key detection error / overrun
   localparam logic [7:0] ScFF = 8'hFF;  // key detection error / overrun

   // Modifier keys
   localparam logic [7:0] ScLshift = 8'h12;
   localparam logic [7:0] ScRshift = 8'h59;
   localparam logic [7:0] ScCtrl   = 8'h14;  // left; right when E0-prefixed
   localparam logic [7:0] ScAlt    = 8'h11;  // left; right when E0-prefixed
   localparam logic [7:0] ScCaps   = 8'h58;

   // Bit positions inside the modifier vector
   localparam int unsigned ModShift = 0;
   localparam int unsigned ModCtrl  = 1;
   localparam int unsigned ModAlt   = 2;
   localparam int unsigned ModCaps  = 3;

   typedef enum logic [1:0] {
      StIdle,
      StPop,
      StDecode
   } kbd_state_e;

   // Keyboard status replies that carry no key information
   function automatic logic is_status_byte(logic [7:0] b);
      return (b == ScAA) || (b == ScFA) || (b == ScEE) || (b == ScFE);
   endfunction

endpackage

// File: rtl/kbd_event_ctrl_if.sv
// kbd_event_ctrl_if: key-event channel between the controller and its consumer.
//   evt_valid  producer -> consumer  event register full
//   evt_ready  consumer -> producer  event accepted on this clock
//   evt_code   final scan code (8'hE1 for Pause)
//   evt_break  1 = key release
//   evt_ext    code was E0/E1-prefixed
//   evt_mods   {caps_lock, alt, ctrl, shift} after this event
// master = producer (kbd_event_ctrl), slave = consumer.
interface kbd_event_ctrl_if;
   logic       evt_valid;
   logic       evt_ready;
   logic [7:0] evt_code;
   logic       evt_break;
   logic       evt_ext;
   logic [3:0] evt_mods;

   modport master (
      output evt_valid,
      output evt_code,
      output evt_break,
      output evt_ext,
      output evt_mods,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_code,
      input  evt_break,
      input  evt_ext,
      input  evt_mods,
      output evt_ready
   );
endinterface

// File: rtl/kbd_mod_tracker.sv
// kbd_mod_tracker: keeps the held state of shift/ctrl/alt keys and the Caps Lock toggle.
//   clk, clr     clock, synchronous active-high reset
//   i_code       decoded scan code of the key event
//   i_ext        event was E0-prefixed (selects right ctrl/alt)
//   i_break      event is a release
//   i_strobe     one-cycle pulse: apply this key event
//   o_mods       current {caps_lock, alt, ctrl, shift}
//   o_mods_nxt   value o_mods takes after the event being strobed now
module kbd_mod_tracker
   import kbd_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic [7:0] i_code,
   input  logic       i_ext,
   input  logic       i_break,
   input  logic       i_strobe,
   output logic [3:0] o_mods,
   output logic [3:0] o_mods_nxt
);

   logic r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt, r_caps_held, r_caps_lock;
   logic w_lshift, w_rshift, w_lctrl, w_rctrl, w_lalt, w_ralt, w_caps_held, w_caps_lock;

   always_comb begin
      w_lshift    = r_lshift;
      w_rshift    = r_rshift;
      w_lctrl     = r_lctrl;
      w_rctrl     = r_rctrl;
      w_lalt      = r_lalt;
      w_ralt      = r_ralt;
      w_caps_held = r_caps_held;
      w_caps_lock = r_caps_lock;
      if (i_strobe) begin
         case (i_code)
            ScLshift: if (!i_ext) w_lshift = !i_break;
            ScRshift: if (!i_ext) w_rshift = !i_break;
            ScCtrl: begin
               if (i_ext) w_rctrl = !i_break;
               else       w_lctrl = !i_break;
            end
            ScAlt: begin
               if (i_ext) w_ralt = !i_break;
               else       w_lalt = !i_break;
            end
            ScCaps: begin
               // Only the first make after a release toggles, so typematic repeats are ignored
               if (i_break) begin
                  w_caps_held = 1'b0;
               end else if (!r_caps_held) begin
                  w_caps_lock = !r_caps_lock;
                  w_caps_held = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_lshift    <= 1'b0;
         r_rshift    <= 1'b0;
         r_lctrl     <= 1'b0;
         r_rctrl     <= 1'b0;
         r_lalt      <= 1'b0;
         r_ralt      <= 1'b0;
         r_caps_held <= 1'b0;
         r_caps_lock <= 1'b0;
      end else begin
         r_lshift    <= w_lshift;
         r_rshift    <= w_rshift;
         r_lctrl     <= w_lctrl;
         r_rctrl     <= w_rctrl;
         r_lalt      <= w_lalt;
         r_ralt      <= w_ralt;
         r_caps_held <= w_caps_held;
         r_caps_lock <= w_caps_lock;
      end
   end

   always_comb begin
      o_mods               = '0;
      o_mods[ModShift]     = r_lshift | r_rshift;
      o_mods[ModCtrl]      = r_lctrl | r_rctrl;
      o_mods[ModAlt]       = r_lalt | r_ralt;
      o_mods[ModCaps]      = r_caps_lock;
      o_mods_nxt           = '0;
      o_mods_nxt[ModShift] = w_lshift | w_rshift;
      o_mods_nxt[ModCtrl]  = w_lctrl | w_rctrl;
      o_mods_nxt[ModAlt]   = w_lalt | w_ralt;
      o_mods_nxt[ModCaps]  = w_caps_lock;
   end

endmodule

// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl: pops bytes from the ps2_keyboard FIFO and assembles them into key events.
//   clk, clr       clock, synchronous active-high reset
//   ps2_byte       FIFO head byte
//   ps2_ready      FIFO non-empty
//   ps2_overflow   FIFO overflow indication
//   nextdata_n     registered active-low pop strobe, one cycle per byte
//   evt            event channel (master side), see kbd_event_ctrl_if
//   ovf_sticky     ps2_overflow seen since reset
//   kbd_err        sticky; keyboard sent 8'h00 or 8'hFF
// Each byte takes IDLE -> POP -> DECODE (3 cycles). No byte is fetched while an event is held.
module kbd_event_ctrl
   import kbd_pkg::*;
#(
   parameter int unsigned PAUSE_LEN = 7
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic [7:0]             ps2_byte,
   input  logic                   ps2_ready,
   input  logic                   ps2_overflow,
   output logic                   nextdata_n,
   kbd_event_ctrl_if.master       evt,
   output logic                   ovf_sticky,
   output logic                   kbd_err
);

   localparam int unsigned SkipW = $clog2(PAUSE_LEN + 1);

   kbd_state_e       r_state, w_state_nxt;
   logic [7:0]       r_byte, w_byte_nxt;
   logic             r_nextdata_n, w_nextdata_n_nxt;
   logic             r_ext_pend, w_ext_nxt;
   logic             r_brk_pend, w_brk_nxt;
   logic [SkipW-1:0] r_skip_cnt, w_skip_nxt;
   logic             r_evt_valid;
   logic [7:0]       r_evt_code;
   logic             r_evt_break;
   logic             r_evt_ext;
   logic [3:0]       r_evt_mods;
   logic             r_ovf;
   logic             r_err;

   logic             w_emit;        // ordinary key event from r_byte
   logic             w_emit_pause;  // last byte of the Pause sequence absorbed
   logic             w_err_set;
   logic [3:0]       w_mods;
   logic [3:0]       w_mods_nxt;

   kbd_mod_tracker u_mod_tracker (
      .clk        (clk),
      .clr        (clr),
      .i_code     (r_byte),
      .i_ext      (r_ext_pend),
      .i_break    (r_brk_pend),
      .i_strobe   (w_emit),
      .o_mods     (w_mods),
      .o_mods_nxt (w_mods_nxt)
   );

   always_comb begin
      w_state_nxt      = r_state;
      w_byte_nxt       = r_byte;
      w_nextdata_n_nxt = 1'b1;
      w_ext_nxt        = r_ext_pend;
      w_brk_nxt        = r_brk_pend;
      w_skip_nxt       = r_skip_cnt;
      w_emit           = 1'b0;
      w_emit_pause     = 1'b0;
      w_err_set        = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (ps2_ready && !r_evt_valid) begin
               w_byte_nxt       = ps2_byte;
               w_nextdata_n_nxt = 1'b0;
               w_state_nxt      = StPop;
            end
         end
         StPop: begin
            w_state_nxt = StDecode;
         end
         StDecode: begin
            w_state_nxt = StIdle;
            if (r_skip_cnt != '0) begin
               w_skip_nxt = r_skip_cnt - SkipW'(1);
               if (r_skip_cnt == SkipW'(1)) w_emit_pause = 1'b1;
            end else if (r_byte == ScE1) begin
               w_skip_nxt = SkipW'(PAUSE_LEN);
            end else if (r_byte == ScE0) begin
               w_ext_nxt = 1'b1;
            end else if (r_byte == ScF0) begin
               w_brk_nxt = 1'b1;
            end else if (is_status_byte(r_byte)) begin
               // status replies may land between a prefix and its code; keep the prefixes
            end else if ((r_byte == Sc00) || (r_byte == ScFF)) begin
               w_err_set = 1'b1;
               w_ext_nxt = 1'b0;
               w_brk_nxt = 1'b0;
            end else if (r_ext_pend && ((r_byte == ScLshift) || (r_byte == ScRshift))) begin
               // E0-prefixed shift codes are fake shifts generated around nav keys
               w_ext_nxt = 1'b0;
               w_brk_nxt = 1'b0;
            end else begin
               w_emit    = 1'b1;
               w_ext_nxt = 1'b0;
               w_brk_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state      <= StIdle;
         r_byte       <= '0;
         r_nextdata_n <= 1'b1;
         r_ext_pend   <= 1'b0;
         r_brk_pend   <= 1'b0;
         r_skip_cnt   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_byte       <= w_byte_nxt;
         r_nextdata_n <= w_nextdata_n_nxt;
         r_ext_pend   <= w_ext_nxt;
         r_brk_pend   <= w_brk_nxt;
         r_skip_cnt   <= w_skip_nxt;
      end
   end

   // Event register. A load never coincides with a held event because nothing is
   // fetched while r_evt_valid is set.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_evt_valid <= 1'b0;
         r_evt_code  <= '0;
         r_evt_break <= 1'b0;
         r_evt_ext   <= 1'b0;
         r_evt_mods  <= '0;
      end else if (w_emit) begin
         r_evt_valid <= 1'b1;
         r_evt_code  <= r_byte;
         r_evt_break <= r_brk_pend;
         r_evt_ext   <= r_ext_pend;
         r_evt_mods  <= w_mods_nxt;
      end else if (w_emit_pause) begin
         r_evt_valid <= 1'b1;
         r_evt_code  <= ScE1;
         r_evt_break <= 1'b0;
         r_evt_ext   <= 1'b1;
         r_evt_mods  <= w_mods;
      end else if (r_evt_valid && evt.evt_ready) begin
         r_evt_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_ovf <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_ovf <= r_ovf | ps2_overflow;
         r_err <= r_err | w_err_set;
      end
   end

   assign nextdata_n    = r_nextdata_n;
   assign evt.evt_valid = r_evt_valid;
   assign evt.evt_code  = r_evt_code;
   assign evt.evt_break = r_evt_break;
   assign evt.evt_ext   = r_evt_ext;
   assign evt.evt_mods  = r_evt_mods;
   assign ovf_sticky    = r_ovf;
   assign kbd_err       = r_err;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Bench for kbd_event_ctrl: a queue models the ps2_keyboard FIFO (pops on a clock edge
// that sees nextdata_n low), a monitor logs accepted events, and a vector table plus
// hand-written sequences compare against hand-computed events.
module tb_kbd_event_ctrl;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [7:0] ps2_byte = 8'h00;
   logic       ps2_ready = 1'b0;
   logic       ps2_overflow = 1'b0;
   logic       nextdata_n;
   logic       ovf_sticky;
   logic       kbd_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   kbd_event_ctrl_if evt_if ();

   kbd_event_ctrl #(
      .PAUSE_LEN (7)
   ) dut (
      .clk          (clk),
      .clr          (clr),
      .ps2_byte     (ps2_byte),
      .ps2_ready    (ps2_ready),
      .ps2_overflow (ps2_overflow),
      .nextdata_n   (nextdata_n),
      .evt          (evt_if.master),
      .ovf_sticky   (ovf_sticky),
      .kbd_err      (kbd_err)
   );

   // FIFO model
   logic [7:0]  fifo_q[$];
   int          pops = 0;
   logic [13:0] cap_q[$];

   always @(posedge clk) begin
      if (!nextdata_n && fifo_q.size() > 0) begin
         void'(fifo_q.pop_front());
         pops++;
      end
   end

   always @(negedge clk) begin
      ps2_ready = (fifo_q.size() != 0);
      ps2_byte  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
   end

   // Event monitor: an event is taken on the next posedge when valid && ready here
   always @(negedge clk) begin
      if (evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1)
         cap_q.push_back({evt_if.evt_code, evt_if.evt_break, evt_if.evt_ext, evt_if.evt_mods});
   end

   function automatic logic [13:0] ev(logic [7:0] c, logic br, logic ex, logic [3:0] m);
      return {c, br, ex, m};
   endfunction

   typedef struct {
      int              n;
      logic [0:7][7:0] b;
      int              nev;
      logic [0:5][13:0] e;
      logic            err;
   } vec_t;

   vec_t vecs[11];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
   endtask

   task automatic check_zero_outputs(string tag);
      check({tag, " nextdata_n"}, 32'(nextdata_n), 32'd1);
      check({tag, " evt_valid"}, 32'(evt_if.evt_valid), 32'd0);
      check({tag, " evt_code"}, 32'(evt_if.evt_code), 32'd0);
      check({tag, " evt_break"}, 32'(evt_if.evt_break), 32'd0);
      check({tag, " evt_ext"}, 32'(evt_if.evt_ext), 32'd0);
      check({tag, " evt_mods"}, 32'(evt_if.evt_mods), 32'd0);
      check({tag, " ovf_sticky"}, 32'(ovf_sticky), 32'd0);
      check({tag, " kbd_err"}, 32'(kbd_err), 32'd0);
   endtask

   initial begin
      int base;
      int lows;

      evt_if.evt_ready = 1'b0;
      vecs[0]  = '{n: 1, b: {8'h1C, 56'h0}, nev: 1,
                   e: {ev(8'h1C, 0, 0, 4'h0), {5{14'h0}}}, err: 1'b0};
      vecs[1]  = '{n: 6, b: {8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 16'h0}, nev: 4,
                   e: {ev(8'h12, 0, 0, 4'h1), ev(8'h1C, 0, 0, 4'h1), ev(8'h1C, 1, 0, 4'h1),
                       ev(8'h12, 1, 0, 4'h0), {2{14'h0}}}, err: 1'b0};
      vecs[2]  = '{n: 6, b: {8'hE0, 8'hF0, 8'h75, 8'hF0, 8'hE0, 8'h75, 16'h0}, nev: 2,
                   e: {ev(8'h75, 1, 1, 4'h0), ev(8'h75, 1, 1, 4'h0), {4{14'h0}}}, err: 1'b0};
      vecs[3]  = '{n: 5, b: {8'hE0, 8'h12, 8'hE0, 8'h59, 8'h1C, 24'h0}, nev: 1,
                   e: {ev(8'h1C, 0, 0, 4'h0), {5{14'h0}}}, err: 1'b0};
      vecs[4]  = '{n: 8, b: {8'h58, 8'h58, 8'h58, 8'hF0, 8'h58, 8'h58, 8'hF0, 8'h58}, nev: 6,
                   e: {ev(8'h58, 0, 0, 4'h8), ev(8'h58, 0, 0, 4'h8), ev(8'h58, 0, 0, 4'h8),
                       ev(8'h58, 1, 0, 4'h8), ev(8'h58, 0, 0, 4'h0), ev(8'h58, 1, 0, 4'h0)},
                   err: 1'b0};
      vecs[5]  = '{n: 8, b: {8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77}, nev: 1,
                   e: {ev(8'hE1, 0, 1, 4'h0), {5{14'h0}}}, err: 1'b0};
      vecs[6]  = '{n: 4, b: {8'h14, 8'hE0, 8'h11, 8'h1C, 32'h0}, nev: 3,
                   e: {ev(8'h14, 0, 0, 4'h2), ev(8'h11, 0, 1, 4'h6), ev(8'h1C, 0, 0, 4'h6),
                       {3{14'h0}}}, err: 1'b0};
      vecs[7]  = '{n: 6, b: {8'hF0, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h1C, 16'h0}, nev: 1,
                   e: {ev(8'h1C, 1, 0, 4'h0), {5{14'h0}}}, err: 1'b0};
      vecs[8]  = '{n: 4, b: {8'hE0, 8'hF0, 8'h00, 8'h1C, 32'h0}, nev: 1,
                   e: {ev(8'h1C, 0, 0, 4'h0), {5{14'h0}}}, err: 1'b1};
      vecs[9]  = '{n: 5, b: {8'h59, 8'hE0, 8'h14, 8'hF0, 8'h59, 24'h0}, nev: 3,
                   e: {ev(8'h59, 0, 0, 4'h1), ev(8'h14, 0, 1, 4'h3), ev(8'h59, 1, 0, 4'h2),
                       {3{14'h0}}}, err: 1'b0};
      vecs[10] = '{n: 3, b: {8'hE0, 8'hFF, 8'h14, 40'h0}, nev: 1,
                   e: {ev(8'h14, 0, 0, 4'h2), {5{14'h0}}}, err: 1'b1};

      // Reset state
      tick(2);
      clr = 1'b0;
      check_zero_outputs("reset");

      // Table-driven vectors, each from a fresh reset with the consumer always ready
      for (int i = 0; i < 11; i++) begin
         do_reset();
         cap_q.delete();
         base = pops;
         evt_if.evt_ready = 1'b1;
         for (int k = 0; k < vecs[i].n; k++) fifo_q.push_back(vecs[i].b[k]);
         tick(3 * vecs[i].n + 10);
         check($sformatf("v%0d pops", i), 32'(pops - base), 32'(vecs[i].n));
         check($sformatf("v%0d nevents", i), 32'(cap_q.size()), 32'(vecs[i].nev));
         for (int k = 0; k < vecs[i].nev; k++) begin
            if (k < cap_q.size())
               check($sformatf("v%0d ev%0d", i, k), 32'(cap_q[k]), 32'(vecs[i].e[k]));
         end
         check($sformatf("v%0d kbd_err", i), 32'(kbd_err), 32'(vecs[i].err));
         check($sformatf("v%0d nextdata_n idle", i), 32'(nextdata_n), 32'd1);
      end

      // Latency and backpressure: consumer stalled with 1C,32 queued
      do_reset();
      cap_q.delete();
      evt_if.evt_ready = 1'b0;
      base = pops;
      fifo_q.push_back(8'h1C);
      fifo_q.push_back(8'h32);
      @(negedge clk); #1;
      @(negedge clk);
      check("lat pop low", 32'(nextdata_n), 32'd0);
      check("lat valid0 a", 32'(evt_if.evt_valid), 32'd0);
      @(negedge clk);
      check("lat pop high", 32'(nextdata_n), 32'd1);
      check("lat valid0 b", 32'(evt_if.evt_valid), 32'd0);
      @(negedge clk);
      check("lat valid", 32'(evt_if.evt_valid), 32'd1);
      check("lat event", 32'({evt_if.evt_code, evt_if.evt_break, evt_if.evt_ext,
                              evt_if.evt_mods}), 32'(ev(8'h1C, 0, 0, 4'h0)));
      lows = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (nextdata_n !== 1'b1) lows++;
      end
      check("bp no pop", 32'(lows), 32'd0);
      check("bp pops", 32'(pops - base), 32'd1);
      check("bp held code", 32'(evt_if.evt_code), 32'h1C);
      check("bp held valid", 32'(evt_if.evt_valid), 32'd1);
      tick(1);
      evt_if.evt_ready = 1'b1;
      tick(12);
      check("bp nevents", 32'(cap_q.size()), 32'd2);
      if (cap_q.size() >= 2) begin
         check("bp ev0", 32'(cap_q[0]), 32'(ev(8'h1C, 0, 0, 4'h0)));
         check("bp ev1", 32'(cap_q[1]), 32'(ev(8'h32, 0, 0, 4'h0)));
      end
      check("bp pops total", 32'(pops - base), 32'd2);

      // Error byte, caps, overflow, then clr during POP
      do_reset();
      cap_q.delete();
      evt_if.evt_ready = 1'b1;
      fifo_q.push_back(8'h00);
      fifo_q.push_back(8'h58);
      tick(12);
      check("err sticky", 32'(kbd_err), 32'd1);
      check("err nevents", 32'(cap_q.size()), 32'd1);
      check("caps mods", 32'(evt_if.evt_mods), 32'h8);
      check("ovf before", 32'(ovf_sticky), 32'd0);
      ps2_overflow = 1'b1;
      tick(1);
      ps2_overflow = 1'b0;
      tick(3);
      check("ovf sticky", 32'(ovf_sticky), 32'd1);
      cap_q.delete();
      base = pops;
      fifo_q.push_back(8'h1C);
      fifo_q.push_back(8'h32);
      @(negedge clk); #1;
      @(negedge clk);
      check("clr in pop low", 32'(nextdata_n), 32'd0);
      clr = 1'b1;
      @(negedge clk);
      check_zero_outputs("clr in pop");
      clr = 1'b0;
      tick(12);
      check("clr nevents", 32'(cap_q.size()), 32'd1);
      if (cap_q.size() >= 1) check("clr ev 32", 32'(cap_q[0]), 32'(ev(8'h32, 0, 0, 4'h0)));
      check("clr pops", 32'(pops - base), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
